// File: rtl/n_accumulator.sv
// n_accumulator: sums blocks of LEN signed samples; saturating mode under N_ACCUMULATOR_SAT_EN
module n_accumulator #(
  parameter int N = 8,
  parameter int ACC_W = 16,
  parameter int LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic                       out_ovf,
  output logic [$clog2(LEN+1)-1:0]   count
);
  localparam int CW = $clog2(LEN+1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_next;
  logic [ACC_W-1:0] acc, ext, sum, acc_next;
  logic ovf, ovf_now, take, last, drain;
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  assign take = in_valid && in_ready;
  assign drain = out_valid && out_ready;
  assign last = count == CW'(LEN-1);
  assign ext = ACC_W'($signed(in_data));
  assign sum = acc + ext;
  assign ovf_now = acc[ACC_W-1] == ext[ACC_W-1] && sum[ACC_W-1] != acc[ACC_W-1];
`ifdef N_ACCUMULATOR_SAT_EN
  assign acc_next = !ovf_now ? sum :
                    acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign acc_next = sum;
`endif
  always_comb begin
    state_next = state;
    if (clr) state_next = ACCUM;
    else if (take && last) state_next = HOLD;
    else if (drain) state_next = ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else state <= state_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      count <= '0;
      ovf <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
    end else if (clr || drain) begin
      acc <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      acc <= acc_next;
      count <= count + CW'(1);
      ovf <= ovf | ovf_now;
      if (last) begin
        out_data <= acc_next;
        out_ovf <= ovf | ovf_now;
      end
    end
  end
endmodule

// File: doc/n_accumulator.md
Name: n_accumulator

Overview:
- Downstream consumer of the N-bit signed adder results: accumulates a block of LEN signed N-bit samples into an ACC_W-bit signed sum.
- Presents the block total on a valid/ready output.
- Tracks signed overflow per block.
- Sits between the adder datapath and any result sink (register file, streaming checker).

Parameters:
- N, 8, sample width (signed two's complement); must match the adder's N.
- ACC_W, 16, accumulator and result width; ACC_W >= N required.
- LEN, 4, samples per block; LEN >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous abort: discards the partial or held block and returns to ACCUM.
- in_valid  input  1  sample valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  N  signed sample (e.g. adder S).
- out_valid  output  1  block result valid.
- out_ready  input  1  sink accepts result.
- out_data  output  ACC_W  signed block sum.
- out_ovf  output  1  at least one signed overflow occurred within the block.
- count  output  $clog2(LEN+1)  samples accepted in the current block.

Behaviour:
- Reset (rst=1 at a clk edge): state=ACCUM, acc=0, count=0, ovf=0, out_valid=0, out_data=0, out_ovf=0. in_ready=1 from the first cycle after reset. rst has priority over clr and all handshakes.
- FSM with two states:
  - ACCUM: in_ready=1, out_valid=0. An input handshake is in_valid && in_ready. On each handshake:
    - acc_next = acc + sign_extend(in_data, ACC_W).
    - count increments.
    - ovf is set sticky if the operand signs are equal and the result sign differs.
  - ACCUM to HOLD: on the handshake where count==LEN-1.
    - out_data takes the final sum, including that sample.
    - out_ovf takes the final sticky flag.
    - out_valid=1 in the next cycle; latency from the last sample to result is 1 clk.
  - HOLD: in_ready=0; out_data and out_ovf stable while out_valid=1 && !out_ready.
  - HOLD to ACCUM: on out_valid && out_ready. acc, count and ovf clear; in_ready=1 in the next cycle. No zero-bubble overlap: minimum period is LEN+1 cycles per block.
- Overflow default: wrap-around (two's complement modulo 2^ACC_W).
- clr=1 (not in reset): next state ACCUM, with acc, count, ovf, out_valid cleared. out_data keeps its last value. An input handshake in the same cycle is dropped.
- LEN=1: every accepted sample produces a result; acc is the sign-extended sample.
- in_valid low in ACCUM: state, acc and count hold.
- count equals LEN while in HOLD, and 0 immediately after the output handshake.
- in_data must be ignored when in_valid=0. X on in_data with in_valid=0 must not propagate.

Optional Feature:
- Macro N_ACCUMULATOR_SAT_EN.
- Defined: on overflow, acc clamps to +(2^(ACC_W-1))-1 when positive overflow occurs, or -(2^(ACC_W-1)) when negative overflow occurs. Later samples continue from the clamped value; out_ovf is still set.
- Undefined: wrap-around as above; out_ovf still reports overflow.

Test Plan:
- Reset then block: LEN=4, ACC_W=16, samples 5, 10, 30, -10 back-to-back -> out_valid 1 clk after the 4th sample; out_data=35, out_ovf=0, count=4.
- Backpressure: same block with out_ready held 0 for 5 cycles -> out_data stays 35, in_ready=0 throughout; in_valid=1 with in_data=99 is not accepted. Releasing out_ready -> in_ready=1 next cycle, count=0.
- Overflow: ACC_W=8, LEN=2, samples 127, 1 -> out_ovf=1. Without the macro out_data=-128; with N_ACCUMULATOR_SAT_EN out_data=127. Samples -128, -1 -> -128 with saturation, 127 with wrap; out_ovf=1 in both cases.
- Mid-block clr and reset: after samples 5, -10, assert clr 1 cycle -> count=0, no out_valid. Next block 1, 2, 3, 4 -> out_data=10. Repeat with rst instead of clr -> same result.
- Gaps and LEN=1: in_valid toggled randomly over 10 random signed samples in [-128, 127] -> out_data equals the sign-extended model sum per block. With LEN=1, sample -7 -> out_data=-7 (0xFFF9 at ACC_W=16).
